// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic {HZ_IDLE, HZ_STALL} hz_state_t;
    typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding mux select for one ID source register; EX/MEM beats MEM/WB.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output fwd_sel_t   sel
);
    always_comb
        sel = (mem_reg_write && mem_rd != REG_ZERO && mem_rd == src) ? FWD_EXMEM :
              (wb_reg_write && wb_rd != REG_ZERO && wb_rd == src) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall FSM, memory-busy freeze and operand forwarding selects.
// Define HAZARD_STATS_EN to build the saturating stall/load-use statistics counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 mem_busy,
    input  logic [NUM_SRC*5-1:0] id_src_num,
    input  logic [NUM_SRC-1:0]   id_src_valid,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write,
    input  logic [4:0]           ex_rd,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd,
    input  logic                 wb_reg_write,
    input  logic [4:0]           wb_rd,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic                 freeze_mem,
    output logic [NUM_SRC*2-1:0] fwd_sel,
    output logic [CNT_W-1:0]     stat_stall_cycles,
    output logic [CNT_W-1:0]     stat_load_use
);
    hz_state_t  state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       detect, accept, stall;

    always_comb begin
        detect = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            detect |= id_src_valid[k] && id_src_num[5*k +: 5] == ex_rd;
        detect = detect && ex_mem_read && ex_reg_write && ex_rd != REG_ZERO;
    end

    // mem_busy outranks flush, which outranks any stall request
    assign accept     = !rst && !mem_busy && !flush && state == HZ_IDLE && detect;
    assign stall      = !rst && !mem_busy && !flush && (state == HZ_STALL || detect);
    assign freeze_mem = !rst && mem_busy;
    assign stall_if   = freeze_mem || stall;
    assign stall_id   = freeze_mem || stall;
    assign bubble_ex  = stall;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (mem_busy) begin
            state_nx = state;
        end else if (flush) begin
            state_nx = HZ_IDLE;
            cnt_nx   = 3'd0;
        end else if (state == HZ_STALL) begin
            cnt_nx   = cnt - 3'd1;
            state_nx = (cnt == 3'd1) ? HZ_IDLE : HZ_STALL;
        end else if (accept && LOAD_STALL > 1) begin
            state_nx = HZ_STALL;
            cnt_nx   = 3'(LOAD_STALL - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_sel_t sel;
        hazard_fwd_sel u_fwd (
            .src           (id_src_num[5*i +: 5]),
            .mem_reg_write (mem_reg_write),
            .mem_rd        (mem_rd),
            .wb_reg_write  (wb_reg_write),
            .wb_rd         (wb_rd),
            .sel           (sel)
        );
        assign fwd_sel[2*i +: 2] = rst ? FWD_RF : sel;
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt, lu_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (stall_id && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (accept && !(&lu_cnt)) lu_cnt <= lu_cnt + CNT_W'(1);
        end
    end
    assign stat_stall_cycles = stall_cnt;
    assign stat_load_use     = lu_cnt;
`else
    assign stat_stall_cycles = {CNT_W{1'b0}};
    assign stat_load_use     = {CNT_W{1'b0}};
`endif
endmodule
